instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface; drives the word-aligned byte address and captures the combinational instruction word returned by the instruction ROM.
- Holds the program counter and fills the IF/ID pipeline register; the MIPS decode stage consumes that register.
- Handles stall, branch/jump redirect and simulation halt, and flags illegal fetch addresses.
- Sits between the instruction ROM and the decode stage of the MIPS core.

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: program counter, IF/ID pipeline register,
// redirect/stall/halt handling and sticky illegal-address detection.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0000_0800,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    // state  | meaning
    // RUN    | fetching one word per unstalled edge
    // HALTED | halt word delivered; waits for a redirect or reset
    // FAULT  | illegal pc seen; everything frozen until reset
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instruction;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic        r_halted;
    logic        r_fetch_fault;
    logic [31:0] r_fault_pc;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_illegal;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_illegal  = (r_pc[1:0] != 2'b00) || (r_pc > (MEM_SIZE - 32'd4));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= RUN;
            r_pc             <= RESET_PC;
            r_if_valid       <= 1'b0;
            r_if_instruction <= 32'h0;
            r_if_pc          <= 32'h0;
            r_if_pc_plus4    <= 32'h0;
            r_halted         <= 1'b0;
            r_fetch_fault    <= 1'b0;
            r_fault_pc       <= 32'h0;
            r_fetch_count    <= 32'h0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid) begin
                        r_pc       <= redirect_target;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        if (w_illegal) begin
                            r_state       <= FAULT;
                            r_fetch_fault <= 1'b1;
                            r_fault_pc    <= r_pc;
                            r_if_valid    <= 1'b0;
                        end else begin
                            r_if_instruction <= imem_instruction;
                            r_if_pc          <= r_pc;
                            r_if_pc_plus4    <= w_pc_plus4;
                            r_if_valid       <= 1'b1;
                            r_pc             <= w_pc_plus4;
                            r_fetch_count    <= r_fetch_count + 32'd1;
                            if (imem_instruction == HALT_WORD) begin
                                r_state  <= HALTED;
                                r_halted <= 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    // The halt was on a wrong path if anything redirects us.
                    if (redirect_valid) begin
                        r_pc       <= redirect_target;
                        r_if_valid <= 1'b0;
                        r_state    <= RUN;
                        r_halted   <= 1'b0;
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

    assign imem_address   = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instruction = r_if_instruction;
    assign if_pc          = r_if_pc;
    assign if_pc_plus4    = r_if_pc_plus4;
    assign halted         = r_halted;
    assign fetch_fault    = r_fetch_fault;
    assign fault_pc       = r_fault_pc;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM model, delivery scoreboard
// checked by a negedge monitor, plus point checks of control state.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [0:511];
    logic [63:0] exp_q [$];

    instr_fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .halted           (halted),
        .fetch_fault      (fetch_fault),
        .fault_pc         (fault_pc),
        .fetch_count      (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imem_instruction = (imem_address < 32'h800) ? rom[imem_address[10:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back({addr, rom[addr[10:2]]});
    endtask

    // Monitor: every change of fetch_count outside reset is one delivery.
    logic [31:0] mon_last;
    logic [31:0] mon_cnt;
    always @(negedge clock) begin
        logic [63:0] e;
        if (reset) begin
            mon_last = 32'h0;
            mon_cnt  = 32'h0;
        end else if (fetch_count !== mon_last) begin
            mon_last = fetch_count;
            mon_cnt  = mon_cnt + 32'd1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery actual_pc=%h required=none", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_valid", {31'h0, if_valid}, 32'h1);
                chk("sb_pc", if_pc, e[63:32]);
                chk("sb_instr", if_instruction, e[31:0]);
                chk("sb_pc_plus4", if_pc_plus4, e[63:32] + 32'd4);
                chk("sb_count", fetch_count, mon_cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 32'h2400_0000 + 32'(i);
        rom[0] = 32'h2008_0001;
        rom[1] = 32'h2009_0002;
        rom[2] = 32'h0109_5020;
        rom[3] = 32'h0000_0000;
        rom[4] = 32'h0000_000C;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        chk("rst_addr", imem_address, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instruction, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        reset = 1'b0;

        // sequential fetch
        push(32'h0); push(32'h4); push(32'h8);
        step(); chk("t1_addr1", imem_address, 32'h4);
        step(); chk("t1_addr2", imem_address, 32'h8);
        step(); chk("t1_addr3", imem_address, 32'hC);
        chk("t1_count", fetch_count, 32'd3);

        // stall holding if_pc=4
        redirect_valid = 1'b1; redirect_target = 32'h4;
        step(); chk("t2_redir_addr", imem_address, 32'h4);
        chk("t2_redir_valid", {31'h0, if_valid}, 32'h0);
        redirect_valid = 1'b0; push(32'h4);
        step(); chk("t2_addr", imem_address, 32'h8);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_hold_pc", if_pc, 32'h4);
            chk("t2_hold_instr", if_instruction, 32'h2009_0002);
            chk("t2_hold_addr", imem_address, 32'h8);
            chk("t2_hold_valid", {31'h0, if_valid}, 32'h1);
            chk("t2_hold_count", fetch_count, 32'd4);
        end
        stall = 1'b0; push(32'h8);
        step(); chk("t2_resume_addr", imem_address, 32'hC);

        // redirect beats stall
        redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
        step(); chk("t3_addr", imem_address, 32'h40);
        chk("t3_valid", {31'h0, if_valid}, 32'h0);
        chk("t3_count", fetch_count, 32'd5);
        redirect_valid = 1'b0; stall = 1'b0; push(32'h40);
        step(); chk("t3_next_addr", imem_address, 32'h44);

        // halt
        redirect_valid = 1'b1; redirect_target = 32'hC;
        step(); chk("t4_addr", imem_address, 32'hC);
        redirect_valid = 1'b0; push(32'hC);
        step(); push(32'h10);
        step();
        chk("t4_halt_valid", {31'h0, if_valid}, 32'h1);
        chk("t4_halted", {31'h0, halted}, 32'h1);
        chk("t4_halt_instr", if_instruction, 32'hC);
        chk("t4_halt_addr", imem_address, 32'h14);
        stall = 1'b1;
        step(); chk("t4_stall_valid", {31'h0, if_valid}, 32'h1);
        stall = 1'b0;
        step(); chk("t4_drop_valid", {31'h0, if_valid}, 32'h0);
        chk("t4_still_halted", {31'h0, halted}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_idle_addr", imem_address, 32'h14);
            chk("t4_idle_count", fetch_count, 32'd8);
        end
        redirect_valid = 1'b1; redirect_target = 32'h0;
        step(); chk("t4_resume_halted", {31'h0, halted}, 32'h0);
        chk("t4_resume_addr", imem_address, 32'h0);
        redirect_valid = 1'b0; push(32'h0);
        step(); chk("t4_resume_next", imem_address, 32'h4);

        // redirect suppresses a halt word fetched on the same edge
        redirect_valid = 1'b1; redirect_target = 32'h10;
        step();
        redirect_target = 32'h20;
        step(); chk("t4b_addr", imem_address, 32'h20);
        chk("t4b_halted", {31'h0, halted}, 32'h0);
        chk("t4b_valid", {31'h0, if_valid}, 32'h0);
        chk("t4b_count", fetch_count, 32'd9);

        // top legal word, then faults
        redirect_target = 32'h7FC;
        step();
        redirect_valid = 1'b0; push(32'h7FC);
        step(); chk("t5_top_addr", imem_address, 32'h800);
        chk("t5_top_fault", {31'h0, fetch_fault}, 32'h0);
        redirect_valid = 1'b1; redirect_target = 32'h802;
        step(); chk("t5_mis_addr", imem_address, 32'h802);
        redirect_valid = 1'b0;
        step();
        chk("t5_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t5_fault_pc", fault_pc, 32'h802);
        chk("t5_fault_valid", {31'h0, if_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_target = 32'h0; stall = 1'b1;
        step(); step();
        chk("t5_frozen_addr", imem_address, 32'h802);
        chk("t5_frozen_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t5_frozen_fault_pc", fault_pc, 32'h802);
        chk("t5_frozen_valid", {31'h0, if_valid}, 32'h0);
        chk("t5_frozen_count", fetch_count, 32'd10);
        redirect_valid = 1'b0; stall = 1'b0;
        reset = 1'b1;
        step();
        chk("t5_rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("t5_rst_fault_pc", fault_pc, 32'h0);
        chk("t5_rst_count", fetch_count, 32'h0);
        chk("t5_rst_addr", imem_address, 32'h0);
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h800;
        step(); chk("t5_range_addr", imem_address, 32'h800);
        redirect_valid = 1'b0;
        step();
        chk("t5_range_fault", {31'h0, fetch_fault}, 32'h1);
        chk("t5_range_fault_pc", fault_pc, 32'h800);
        chk("t5_range_valid", {31'h0, if_valid}, 32'h0);
        step(); step();

        chk("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
